// File: rtl/wallace_mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wallace_mult_arbiter_if
// Brief    : Requester, multiplier and response bundle of wallace_mult_arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface wallace_mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic                  drain;
  logic [15:0]           mul_a;
  logic [15:0]           mul_b;
  logic [31:0]           mul_p;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_p;
  logic                  idle;

  // slave = arbiter side, master = requesters plus multiplier side
  modport slave (
    input  req_valid, req_a, req_b, drain, mul_p,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, idle
  );
  modport master (
    output req_valid, req_a, req_b, drain, mul_p,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, idle
  );
endinterface
`default_nettype wire

// File: rtl/wallace_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wallace_mult_arbiter
// Brief    : Round-robin sharing of one pipelined 16x16 multiplier between
//            NUM_REQ requesters; products are routed back by a tag pipeline.
//            Optional WALLACE_ARB_STATS_EN adds issue_cnt / grant_hist.
// Revision : 1.0  initial release
// ============================================================================
module wallace_mult_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = 5,
  parameter int ID_W     = 2
) (
  input  wire                      clk,
  input  wire                      rst,
  wallace_mult_arbiter_if.slave    bus
`ifdef WALLACE_ARB_STATS_EN
  ,
  output logic [31:0]              issue_cnt,
  output logic [8*NUM_REQ-1:0]     grant_hist
`endif
);

  localparam int              c_cnt_w   = $clog2(PIPE_LAT + 2);
  localparam logic [ID_W-1:0] c_ptr_rst = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]    r_ptr;
  logic [15:0]        r_mul_a;
  logic [15:0]        r_mul_b;
  logic [PIPE_LAT:0]  r_tag_vld;
  logic [ID_W-1:0]    r_tag_id [0:PIPE_LAT];
  logic [c_cnt_w-1:0] r_cnt;

  logic               w_found;
  logic [ID_W-1:0]    w_grant_id;
  logic               w_grant_en;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_xfer;
  logic               w_rsp;

  // First valid requester after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && bus.req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found    = 1'b1;
        w_grant_id = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  // rst in the enable keeps req_ready low while reset is asserted.
  assign w_grant_en = w_found && !bus.drain && rst;

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_en && (w_grant_id == ID_W'(i))) begin
        w_ready[i] = 1'b1;
      end
    end
  end

  assign w_xfer = |(bus.req_valid & w_ready);
  assign w_rsp  = r_tag_vld[PIPE_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= c_ptr_rst;
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else if (w_xfer) begin
      r_ptr   <= w_grant_id;
      r_mul_a <= bus.req_a[int'(w_grant_id)*16 +: 16];
      r_mul_b <= bus.req_b[int'(w_grant_id)*16 +: 16];
    end
  end

  // Free-running tag pipeline; clearing it on reset discards in-flight results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_vld <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) begin
        r_tag_id[i] <= '0;
      end
    end else begin
      r_tag_vld   <= {r_tag_vld[PIPE_LAT-1:0], w_xfer};
      r_tag_id[0] <= w_xfer ? w_grant_id : '0;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_xfer && !w_rsp) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end else if (!w_xfer && w_rsp) begin
      r_cnt <= r_cnt - c_cnt_w'(1);
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.rsp_valid = w_rsp;
  assign bus.rsp_id    = r_tag_id[PIPE_LAT];
  assign bus.rsp_p     = w_rsp ? bus.mul_p : 32'd0;
  assign bus.idle      = (r_cnt == '0);

`ifdef WALLACE_ARB_STATS_EN
  logic [31:0] r_issue_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_cnt <= '0;
    end else if (w_xfer) begin
      r_issue_cnt <= r_issue_cnt + 32'd1;
    end
  end

  assign issue_cnt = r_issue_cnt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hist
    logic [7:0] r_hist;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_hist <= '0;
      end else if (w_xfer && (w_grant_id == ID_W'(i)) && (r_hist != 8'hFF)) begin
        r_hist <= r_hist + 8'd1;
      end
    end

    assign grant_hist[8*i +: 8] = r_hist;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wallace_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wallace_mult_arbiter
// Brief    : Directed scoreboard bench for wallace_mult_arbiter with a
//            behavioural PIPE_LAT-stage multiplier model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wallace_mult_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int PIPE_LAT = 5;
  localparam int ID_W     = 2;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] p;
    int          due;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  logic  mon_en = 1'b0;
  exp_t  sb[$];
  logic [31:0] mpipe [PIPE_LAT];

`ifdef WALLACE_ARB_STATS_EN
  logic [31:0]          issue_cnt;
  logic [8*NUM_REQ-1:0] grant_hist;
`endif

  wallace_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  wallace_mult_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PIPE_LAT(PIPE_LAT),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef WALLACE_ARB_STATS_EN
    ,
    .issue_cnt (issue_cnt),
    .grant_hist(grant_hist)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: operands sampled each edge, product PIPE_LAT edges later.
  always @(posedge clk) begin
    mpipe[0] <= {16'd0, bus.mul_a} * {16'd0, bus.mul_b};
    for (int i = 1; i < PIPE_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mul_p = mpipe[PIPE_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: a response is due exactly at its scheduled cycle, none otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
        chk("rsp_p", bus.rsp_p, sb[0].p);
        void'(sb.pop_front());
      end else begin
        chk("rsp_valid_quiet", 32'(bus.rsp_valid), 32'd0);
        chk("rsp_p_quiet", bus.rsp_p, 32'd0);
      end
    end
  end

  task automatic step(input logic [3:0] vld, input logic drn, input int exp_id,
                      input int lane, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    @(negedge clk);
    if (lane >= 0) begin
      bus.req_a[16*lane +: 16] = a;
      bus.req_b[16*lane +: 16] = b;
    end
    bus.req_valid = vld;
    bus.drain     = drn;
    #1;
    chk("req_ready", 32'(bus.req_ready), (exp_id < 0) ? 32'd0 : (32'd1 << exp_id));
    if (exp_id >= 0) begin
      e.id  = 2'(exp_id);
      e.p   = 32'(bus.req_a[16*exp_id +: 16]) * 32'(bus.req_b[16*exp_id +: 16]);
      e.due = cyc + 1 + PIPE_LAT;
      sb.push_back(e);
    end
  endtask

  task automatic go(input logic [3:0] vld, input logic drn, input int exp_id);
    step(vld, drn, exp_id, -1, 16'd0, 16'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
    chk({tag, "_rsp_p"}, bus.rsp_p, 32'd0);
    chk({tag, "_idle"}, 32'(bus.idle), 32'd1);
    chk({tag, "_mul_a"}, 32'(bus.mul_a), 32'd0);
    chk({tag, "_mul_b"}, 32'(bus.mul_b), 32'd0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.drain     = 1'b0;

    // Reset state, with every requester asserting valid.
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = '0;
    mon_en        = 1'b1;

    // Single request from requester 2; 300*200 = 60000.
    step(4'b0100, 1'b0, 2, 2, 16'd300, 16'd200);
    chk("single_exp_p", sb[0].p, 32'd60000);
    for (int k = 0; k <= PIPE_LAT; k++) begin
      go(4'b0000, 1'b0, -1);
      chk("single_idle_busy", 32'(bus.idle), 32'd0);
    end
    go(4'b0000, 1'b0, -1);
    chk("single_idle_done", 32'(bus.idle), 32'd1);

    // Full contention from reset: grants 0,1,2,3,0,1,2,3.
    pulse_rst();
    step(4'hF, 1'b0, 0, 0, 16'hFFFF, 16'hFFFF);
    chk("ffff_exp_p", sb[0].p, 32'hFFFE0001);
    step(4'hF, 1'b0, 1, 1, 16'h1234, 16'h5678);
    step(4'hF, 1'b0, 2, 2, 16'h0000, 16'hABCD);
    step(4'hF, 1'b0, 3, 3, 16'h8000, 16'h0002);
    for (int k = 4; k < 8; k++) go(4'hF, 1'b0, k % 4);

    // Drain with requesters still valid: no grants, in-flight ops complete.
    go(4'hF, 1'b1, -1);
    chk("drain_idle_busy", 32'(bus.idle), 32'd0);
    repeat (PIPE_LAT + 1) go(4'hF, 1'b1, -1);
    chk("drain_idle_done", 32'(bus.idle), 32'd1);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    go(4'h0, 1'b0, -1);

    // Reset with three operations in flight (pointer was left at 3).
    go(4'b1010, 1'b0, 1);
    go(4'b1010, 1'b0, 3);
    go(4'b1010, 1'b0, 1);
    go(4'b0000, 1'b0, -1);
    chk("midop_idle_busy", 32'(bus.idle), 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.req_valid = 4'hF;
    sb.delete();
    #1;
    check_reset_outputs("midop_reset");
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = '0;
    repeat (PIPE_LAT + 2) go(4'h0, 1'b0, -1);
    go(4'hF, 1'b0, 0);
    repeat (PIPE_LAT + 2) go(4'h0, 1'b0, -1);
    chk("midop_sb_empty", 32'(sb.size()), 32'd0);

    // Back-to-back from requester 1 alone, then three from requester 3.
    pulse_rst();
    for (int k = 0; k < 10; k++) step(4'b0010, 1'b0, 1, 1, 16'($urandom), 16'($urandom));
    for (int k = 0; k < 3; k++) step(4'b1000, 1'b0, 3, 3, 16'($urandom), 16'($urandom));
    repeat (PIPE_LAT + 2) go(4'h0, 1'b0, -1);
    chk("b2b_idle_done", 32'(bus.idle), 32'd1);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

`ifdef WALLACE_ARB_STATS_EN
    chk("issue_cnt", issue_cnt, 32'd13);
    chk("grant_hist0", 32'(grant_hist[7:0]), 32'd0);
    chk("grant_hist1", 32'(grant_hist[15:8]), 32'd10);
    chk("grant_hist2", 32'(grant_hist[23:16]), 32'd0);
    chk("grant_hist3", 32'(grant_hist[31:24]), 32'd3);
`endif

    @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wallace_mult_arbiter.md
# wallace_mult_arbiter

Round-robin arbiter that shares one pipelined 16x16 Wallace multiplier between NUM_REQ requesters. It accepts at most one operand pair per cycle and drives it into the multiplier. It tracks each issued operation through the multiplier pipeline with a tag shift register, and returns the 32-bit product to the originating requester exactly PIPE_LAT cycles after issue. It sits between the requesting datapath units and the wallace_multiplier instance.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- PIPE_LAT, default 5: cycles from operands stable on mul_a/mul_b to the product valid on mul_p. Must match the multiplier instance.
- ID_W, default 2: width of requester index, equal to clog2(NUM_REQ).
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
- req_a  input  16*NUM_REQ  packed multiplicands; requester i uses bits [16i+15:16i].
- req_b  input  16*NUM_REQ  packed multipliers, same packing as req_a.
- drain  input  1  when high, no new grants are issued.
- mul_a  output  16  registered operand A to the multiplier.
- mul_b  output  16  registered operand B to the multiplier.
- mul_p  input  32  multiplier product.
- rsp_valid  output  1  product valid for one cycle.
- rsp_id  output  ID_W  requester index of rsp_p.
- rsp_p  output  32  product; forced to 0 when rsp_valid=0.
- idle  output  1  high when no operation is in flight.

## Operation
- **Grant rule.** req_ready is combinational from req_valid and the priority pointer. Exactly one bit is set when any req_valid is high and drain=0; otherwise all bits are 0. A transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
- **Round-robin search.** The search starts at index ptr+1 and wraps modulo NUM_REQ. ptr updates to the granted index only on a transfer and holds otherwise.
- **Issue.** On a transfer edge, mul_a/mul_b load the winner's operands. The tag shift register entry 0 loads {valid=1, id=winner}.
- **No transfer.** mul_a/mul_b hold their values and entry 0 loads valid=0.
- **Tag shift register.** PIPE_LAT+1 entries, shifting every cycle with no stalls. rsp_valid and rsp_id come from the last entry. rsp_p = mul_p when rsp_valid=1.
- **No response backpressure.** Requesters must accept rsp_valid whenever it is asserted.
- **In-flight counter.** An outstanding counter tracks operations in flight, range 0..PIPE_LAT+1.
  - +1 on a transfer, -1 on rsp_valid; both in the same cycle leaves it unchanged.
  - idle = (count==0).
- **Drain.** drain masks grants only; in-flight operations complete normally. Raising drain in the same cycle as a would-be grant blocks that grant.
- **Arithmetic.** Operands are unsigned; the product is the full 32 bits with no truncation.

## Timing
- **Reset values.** On rst low: req_ready=0 (forced, regardless of req_valid), mul_a=0, mul_b=0, all tags invalid, ptr=NUM_REQ-1 (so requester 0 has first priority), count=0. Outputs are therefore rsp_valid=0, rsp_id=0, rsp_p=0, idle=1.
- **Latency.** A transfer at edge E gives mul_a/mul_b valid in the cycle after E. rsp_valid=1 with the matching product in the cycle following edge E+PIPE_LAT.
- **Throughput.** One operation per cycle sustained. Back-to-back grants to the same requester are allowed when it is the only one requesting.
- **Reset mid-operation.** All tags clear immediately, so in-flight results are discarded and no rsp_valid is produced for them, even though the multiplier's pipeline still holds data.
- **Response ordering.** Responses return in issue order, one per cycle at most.
- **Boundary conditions.**
  - A requester dropping req_valid without a grant is legal; the operation is not issued.
  - A simultaneous transfer and response at count==PIPE_LAT+1 is legal.

## Configuration
- **With WALLACE_ARB_STATS_EN defined:**
  - Adds output issue_cnt [31:0], which counts transfers, resets to 0 and wraps at 2^32.
  - Adds output grant_hist [8*NUM_REQ-1:0], one saturating 8-bit count of transfers per requester.
- **Without WALLACE_ARB_STATS_EN:** these ports and registers do not exist, and behaviour is otherwise identical.

## Test plan
- **Single request.** Requester 2 presents a=16'd300, b=16'd200 with others idle → req_ready=4'b0100. rsp_valid is high with rsp_id=2 and rsp_p=32'd60000 exactly PIPE_LAT+1 cycles after the transfer edge. idle returns to 1 the cycle after the response.
- **Full contention.** All four requesters hold valid for 8 cycles after reset → grants 0,1,2,3,0,1,2,3. Responses return in that order with correct products, including a=b=16'hFFFF → 32'hFFFE0001.
- **Drain.** drain is raised while requesters stay valid → req_ready=0 from that cycle. The operations already in flight return their responses, and idle=1 once the last one has returned.
- **Reset mid-operation.** rst is pulsed low with 3 operations in flight → no rsp_valid for those operations. All outputs take their reset values, and the next grant goes to requester 0.
- **Back-to-back.** Requester 1 alone issues 10 random pairs on consecutive cycles → 10 consecutive responses checked against a*b.
- **Statistics (macro defined).** 10 transfers from requester 1 and 3 from requester 3 → issue_cnt=13, grant_hist lanes 1 and 3 = 10 and 3, other lanes 0.
